// File: rtl/mc_fetch_unit_pkg.sv
// Shared definitions for the multicycle MIPS fetch stage: next-PC select
// codes (also used by the controller), reset PC default, FSM state codes
// and a branch-offset helper.
package mc_fetch_unit_pkg;

   // Next-PC select encoding driven by the controller
   localparam logic [2:0] NPC_PC4 = 3'b000;
   localparam logic [2:0] NPC_J   = 3'b001;
   localparam logic [2:0] NPC_BR  = 3'b011;
   localparam logic [2:0] NPC_JR  = 3'b100;

   // Address of the first instruction fetched after reset
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   // Fetch FSM state codes
   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   // Sign-extended word offset of a branch immediate, in bytes
   function automatic logic [31:0] br_offset(input logic [15:0] imm16);
      br_offset = {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage : mc_fetch_unit_pkg

// File: rtl/mc_fetch_unit_npc_calc.sv
// Next-PC computation for the fetch stage. Purely combinational: selects
// between sequential, jump, branch and register-jump targets and flags a
// misaligned register-jump target.
module npc_calc
   import mc_fetch_unit_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [25:0] instr_idx,
   input  logic [31:0] rs_val,
   input  logic [2:0]  npc_sel,
   output logic [31:0] npc,
   output logic        misalign
);

   // Target select; unknown select codes fall back to the sequential PC
   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave it unassigned, which would otherwise infer a latch.
      npc      = pc_plus4;
      misalign = 1'b0;
      case (npc_sel)
         NPC_J:   npc = {pc_plus4[31:28], instr_idx, 2'b00};
         NPC_BR:  npc = pc_plus4 + br_offset(instr_idx[15:0]);
         NPC_JR: begin
            // Low bits are forced to zero; the caller records the fault
            npc      = {rs_val[31:2], 2'b00};
            misalign = |rs_val[1:0];
         end
         default: npc = pc_plus4;
      endcase
   end

endmodule : npc_calc

// File: rtl/mc_fetch_unit.sv
// Instruction-fetch stage of the multicycle MIPS core. Owns PC and IR,
// fetches over a req/ack handshake, presents decoded IR fields to the
// controller and commits the next PC when the controller pulses pc_we.
module mc_fetch_unit
   import mc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          IM_TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_we,
   input  logic [2:0]  npc_sel,
   input  logic [31:0] rs_val,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rdata,
   input  logic        im_ack,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic [5:0]  funct,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [15:0] imm16,
   output logic        ir_valid,
   output logic        fetch_busy,
   output logic        proto_err,
   output logic        align_err,
   output logic        fetch_err
);

   localparam int             CNT_W   = $clog2(IM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(IM_TIMEOUT);

   logic [0:0]       state_q,     state_d;
   logic [31:0]      pc_q,        pc_d;
   logic [31:0]      instr_q,     instr_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             proto_err_q, proto_err_d;
   logic             align_err_q, align_err_d;
   logic             fetch_err_q, fetch_err_d;

   logic [31:0]      npc;
   logic             npc_misalign;
   logic [31:0]      pc_plus4_w;

   assign pc_plus4_w = pc_q + 32'd4;

   npc_calc u_npc_calc (
      .pc_plus4  (pc_plus4_w),
      .instr_idx (instr_q[25:0]),
      .rs_val    (rs_val),
      .npc_sel   (npc_sel),
      .npc       (npc),
      .misalign  (npc_misalign)
   );

   // Next-state logic: fetch handshake, PC commit, timeout and sticky errors
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      cnt_d       = cnt_q;
      proto_err_d = proto_err_q;
      align_err_d = align_err_q;
      case (state_q)
         ST_FETCH: begin
            if (im_ack) begin
               instr_d = im_rdata;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else if (cnt_q != TMO_CNT) begin
               cnt_d = cnt_q + 1'b1;
            end
            // The controller must wait for the fetch; the request is dropped
            if (pc_we) proto_err_d = 1'b1;
         end
         ST_HOLD: begin
            // A stray ack while holding is ignored
            if (pc_we) begin
               pc_d    = npc;
               state_d = ST_FETCH;
               if (npc_misalign) align_err_d = 1'b1;
            end
         end
         default: state_d = ST_FETCH;
      endcase
      // Sets the cycle the counter reaches the limit; the fetch keeps going
      fetch_err_d = fetch_err_q | (cnt_d == TMO_CNT);
   end

   // State registers with synchronous reset; reset wins over a same-cycle ack
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      if (rst) begin
         state_q     <= ST_FETCH;
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         cnt_q       <= '0;
         proto_err_q <= 1'b0;
         align_err_q <= 1'b0;
         fetch_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         cnt_q       <= cnt_d;
         proto_err_q <= proto_err_d;
         align_err_q <= align_err_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   assign im_req     = (state_q == ST_FETCH);
   assign fetch_busy = (state_q == ST_FETCH);
   assign ir_valid   = (state_q == ST_HOLD);
   assign im_addr    = pc_q;
   assign pc         = pc_q;
   assign pc_plus4   = pc_plus4_w;
   assign instr      = instr_q;

   // IR fields decode the register unconditionally, stale or not
   assign op         = instr_q[31:26];
   assign rs         = instr_q[25:21];
   assign rt         = instr_q[20:16];
   assign rd         = instr_q[15:11];
   assign imm16      = instr_q[15:0];
   assign funct      = instr_q[5:0];

   assign proto_err  = proto_err_q;
   assign align_err  = align_err_q;
   assign fetch_err  = fetch_err_q;

endmodule : mc_fetch_unit

// File: tb/tb_mc_fetch_unit.sv
// Directed bench for mc_fetch_unit: reset, fetch handshake, each next-PC
// mode, stray ack, protocol/alignment/timeout errors and reset mid-fetch.
module tb_mc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_we;
   logic [2:0]  npc_sel;
   logic [31:0] rs_val;
   logic        im_req;
   logic [31:0] im_addr;
   logic [31:0] im_rdata;
   logic        im_ack;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] instr;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic        ir_valid;
   logic        fetch_busy;
   logic        proto_err;
   logic        align_err;
   logic        fetch_err;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   mc_fetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .pc_we      (pc_we),
      .npc_sel    (npc_sel),
      .rs_val     (rs_val),
      .im_req     (im_req),
      .im_addr    (im_addr),
      .im_rdata   (im_rdata),
      .im_ack     (im_ack),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .instr      (instr),
      .op         (op),
      .funct      (funct),
      .rs         (rs),
      .rt         (rt),
      .rd         (rd),
      .imm16      (imm16),
      .ir_valid   (ir_valid),
      .fetch_busy (fetch_busy),
      .proto_err  (proto_err),
      .align_err  (align_err),
      .fetch_err  (fetch_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // One clock, then settle so outputs are sampled away from the edge
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic ack(input logic [31:0] data);
      im_ack   = 1'b1;
      im_rdata = data;
      step();
      im_ack   = 1'b0;
      im_rdata = '0;
   endtask

   task automatic commit(input logic [2:0] sel, input logic [31:0] rsv);
      pc_we   = 1'b1;
      npc_sel = sel;
      rs_val  = rsv;
      step();
      pc_we   = 1'b0;
      npc_sel = 3'b000;
      rs_val  = '0;
   endtask

   initial begin
      rst = 1'b1; pc_we = 1'b0; npc_sel = 3'b000; rs_val = '0;
      im_rdata = '0; im_ack = 1'b0;
      step(2);
      check("rst_pc",        pc,        32'h0000_3000);
      check("rst_instr",     instr,     32'h0);
      check("rst_ir_valid",  ir_valid,  32'h0);
      check("rst_im_req",    im_req,    32'h1);
      check("rst_errs",      {proto_err, align_err, fetch_err}, 32'h0);
      rst = 1'b0;

      // Three cycles without ack: request stays up at the reset PC
      step(3);
      check("wait_im_req",   im_req,     32'h1);
      check("wait_im_addr",  im_addr,    32'h0000_3000);
      check("wait_ir_valid", ir_valid,   32'h0);
      check("wait_busy",     fetch_busy, 32'h1);

      // lui $1,1 returns
      ack(32'h3C01_0001);
      check("lui_ir_valid",  ir_valid,   32'h1);
      check("lui_op",        op,         32'h0F);
      check("lui_rt",        rt,         32'h1);
      check("lui_imm16",     imm16,      32'h0001);
      check("lui_rs",        rs,         32'h0);
      check("lui_im_req",    im_req,     32'h0);
      check("lui_busy",      fetch_busy, 32'h0);
      check("lui_pc_plus4",  pc_plus4,   32'h0000_3004);

      // Sequential commits 0x3000 -> 0x3004 -> 0x3008
      commit(3'b000, 32'h0);
      check("seq1_pc",       pc,         32'h0000_3004);
      check("seq1_ir_valid", ir_valid,   32'h0);
      ack(32'h0000_0000);
      commit(3'b000, 32'h0);
      check("seq2_im_addr",  im_addr,    32'h0000_3008);
      check("seq2_im_req",   im_req,     32'h1);
      check("seq2_ir_valid", ir_valid,   32'h0);

      // beq with offset -1 at 0x3008 branches to itself
      ack(32'h1000_FFFF);
      check("br_op",         op,         32'h04);
      check("br_imm16",      imm16,      32'hFFFF);
      check("br_pc_plus4",   pc_plus4,   32'h0000_300C);
      // Stray ack while holding must not disturb IR
      ack(32'hFFFF_FFFF);
      check("hold_ack_instr",    instr,    32'h1000_FFFF);
      check("hold_ack_ir_valid", ir_valid, 32'h1);
      commit(3'b011, 32'h0);
      check("br_pc",         pc,         32'h0000_3008);
      check("br_ir_valid",   ir_valid,   32'h0);
      step();
      check("br_ir_valid_2", ir_valid,   32'h0);

      // j 0x0000C03 -> 0x300C
      ack(32'h0800_0C03);
      commit(3'b001, 32'h0);
      check("j_pc",          pc,         32'h0000_300C);

      // jr $2 with misaligned target 0x3011 -> 0x3010, align_err
      ack(32'h0040_0008);
      check("jr_rs",         rs,         32'h2);
      check("jr_funct",      funct,      32'h08);
      check("jr_ir_valid",   ir_valid,   32'h1);
      commit(3'b100, 32'h0000_3011);
      check("jr_pc",         pc,         32'h0000_3010);
      check("jr_align_err",  align_err,  32'h1);

      // Slow memory: 20 cycles without ack, pc_we pulsed mid-fetch
      step(5);
      commit(3'b001, 32'h0);
      check("proto_err",     proto_err,  32'h1);
      check("proto_pc",      pc,         32'h0000_3010);
      check("proto_busy",    fetch_busy, 32'h1);
      step(9);
      check("tmo_15",        fetch_err,  32'h0);
      step();
      check("tmo_16",        fetch_err,  32'h1);
      step(4);
      check("tmo_im_req",    im_req,     32'h1);
      check("tmo_pc",        pc,         32'h0000_3010);
      ack(32'h2402_0005);
      check("tmo_ack_valid", ir_valid,   32'h1);
      check("tmo_ack_instr", instr,      32'h2402_0005);
      check("sticky_errs",   {proto_err, align_err, fetch_err}, 32'h7);

      // Undefined select code behaves as pc+4
      commit(3'b111, 32'h0000_0040);
      check("other_pc",      pc,         32'h0000_3014);

      // Aligned jr back to 0x3010; align_err stays set
      ack(32'h0040_0008);
      commit(3'b100, 32'h0000_3010);
      check("jr2_pc",        pc,         32'h0000_3010);
      check("jr2_align_err", align_err,  32'h1);

      // Reset during fetch of 0x3010 with a late ack in the same cycle
      rst = 1'b1; im_ack = 1'b1; im_rdata = 32'hDEAD_BEEF;
      step();
      rst = 1'b0; im_ack = 1'b0; im_rdata = '0;
      check("mrst_pc",       pc,         32'h0000_3000);
      check("mrst_ir_valid", ir_valid,   32'h0);
      check("mrst_instr",    instr,      32'h0);
      check("mrst_errs",     {proto_err, align_err, fetch_err}, 32'h0);
      check("mrst_im_req",   im_req,     32'h1);
      step();
      check("mrst_ir_valid_2", ir_valid, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_mc_fetch_unit
